// File: rtl/swerv_arb_pkg.sv
// Shared types for the two-master AXI read-address arbiter.
//   ARB_ID_W     : per-master AXI ID width the payload struct is sized for
//   CNT_W        : width of the per-master outstanding-burst counters
//   gnt_idx_t    : index of the granted master (0 = m0, 1 = m1)
//   ar_payload_t : registered downstream AR payload (id, addr, len, size)
package swerv_arb_pkg;

  localparam int ARB_ID_W = 4;
  localparam int CNT_W    = 4;

  typedef logic gnt_idx_t;

  typedef struct packed {
    logic [ARB_ID_W:0] id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
  } ar_payload_t;

  function automatic gnt_idx_t onehot_to_idx(input logic [1:0] gnt);
    return gnt_idx_t'(gnt[1]);
  endfunction

endpackage

// File: rtl/swerv_arb_rr2.sv
// Two-request round-robin arbiter.
//   clk, rst_l : core clock, async active-low reset
//   req[1:0]   : request vector (bit 0 = m0, bit 1 = m1)
//   en         : grant enable (downstream slot free)
//   gnt[1:0]   : combinational one-hot grant
module swerv_arb_rr2
  import swerv_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr_q names the master that wins a tie
  gnt_idx_t ptr_q;
  gnt_idx_t ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    // after a grant, the other master gets priority
    ptr_d = ptr_q;
    if (|gnt) ptr_d = gnt_idx_t'(gnt[0]);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/swerv_axi_rd_arb.sv
// Two-master AXI read arbiter onto one downstream read port.
//   m0_* / m1_* : upstream AR channels (valid/ready/id/addr/len/size) and
//                 R channels (valid/ready/id/data/resp/last)
//   s_*         : downstream AR channel (id carries the master index in its
//                 MSB) and R channel, routed back by s_rid[ID_W]
//   err_unexp_r : sticky flag, an R beat arrived for a master with no
//                 outstanding bursts
// AR is registered (one slot); R is a purely combinational router.
module swerv_axi_rd_arb
  import swerv_arb_pkg::*;
#(
  parameter int ID_W    = ARB_ID_W,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_l,

  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [ID_W-1:0] m0_arid,
  input  logic [31:0]     m0_araddr,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [ID_W-1:0] m0_rid,
  output logic [63:0]     m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rlast,

  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [ID_W-1:0] m1_arid,
  input  logic [31:0]     m1_araddr,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [ID_W-1:0] m1_rid,
  output logic [63:0]     m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rlast,

  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [ID_W:0]   s_arid,
  output logic [31:0]     s_araddr,
  output logic [7:0]      s_arlen,
  output logic [2:0]      s_arsize,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [ID_W:0]   s_rid,
  input  logic [63:0]     s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rlast,

  output logic            err_unexp_r
);

  logic                        s_arvalid_q, s_arvalid_d;
  ar_payload_t                 pay_q, pay_d;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic [1:0]                  req;
  logic [1:0]                  gnt;
  logic                        slot_free;
  gnt_idx_t                    gnt_idx;
  logic [ID_W-1:0]             arid_sel;
  logic                        r_sel;
  logic                        r_hs;
  logic [1:0]                  dec;

  // ---------------- AR path ----------------
  assign req[0]    = m0_arvalid && (cnt_q[0] < CNT_W'(MAX_OUT));
  assign req[1]    = m1_arvalid && (cnt_q[1] < CNT_W'(MAX_OUT));
  // rst_l gates the grant so arready is low the instant reset asserts
  assign slot_free = (!s_arvalid_q || s_arready) && rst_l;

  swerv_arb_rr2 u_rr (
    .clk   (clk),
    .rst_l (rst_l),
    .req   (req),
    .en    (slot_free),
    .gnt   (gnt)
  );

  assign m0_arready = gnt[0];
  assign m1_arready = gnt[1];
  assign gnt_idx    = onehot_to_idx(gnt);
  assign arid_sel   = gnt_idx ? m1_arid : m0_arid;

  always_comb begin
    pay_d       = pay_q;
    s_arvalid_d = s_arvalid_q;
    if (|gnt) begin
      s_arvalid_d = 1'b1;
      pay_d.id    = (ARB_ID_W+1)'({gnt_idx, arid_sel});
      pay_d.addr  = gnt_idx ? m1_araddr : m0_araddr;
      pay_d.len   = gnt_idx ? m1_arlen  : m0_arlen;
      pay_d.size  = gnt_idx ? m1_arsize : m0_arsize;
    end else if (s_arready) begin
      s_arvalid_d = 1'b0;
    end
  end

  assign s_arvalid = s_arvalid_q;
  assign s_arid    = (ID_W+1)'(pay_q.id);
  assign s_araddr  = pay_q.addr;
  assign s_arlen   = pay_q.len;
  assign s_arsize  = pay_q.size;

  // ---------------- R path ----------------
  assign r_sel     = s_rid[ID_W];
  assign m0_rvalid = s_rvalid && !r_sel && rst_l;
  assign m1_rvalid = s_rvalid &&  r_sel && rst_l;
  assign s_rready  = rst_l && (r_sel ? m1_rready : m0_rready);
  assign r_hs      = s_rvalid && s_rready;

  assign m0_rid    = s_rid[ID_W-1:0];
  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rid    = s_rid[ID_W-1:0];
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_rlast  = s_rlast;

  // ---------------- outstanding counters ----------------
  always_comb begin
    cnt_d = cnt_q;
    dec   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // a beat for an idle master is flagged, never allowed to underflow
      dec[i] = r_hs && (r_sel == 1'(i)) && s_rlast && (cnt_q[i] != '0);
      if (gnt[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!gnt[i] && dec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
    err_d = err_q || (r_hs && (cnt_q[r_sel] == '0));
  end

  assign err_unexp_r = err_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s_arvalid_q <= 1'b0;
      pay_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      s_arvalid_q <= s_arvalid_d;
      pay_q       <= pay_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_swerv_axi_rd_arb.sv
module tb_swerv_axi_rd_arb;

  localparam int ID_W    = 4;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic            m0_arvalid, m0_arready, m1_arvalid, m1_arready;
  logic [ID_W-1:0] m0_arid, m1_arid;
  logic [31:0]     m0_araddr, m1_araddr;
  logic [7:0]      m0_arlen, m1_arlen;
  logic [2:0]      m0_arsize, m1_arsize;
  logic            m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
  logic [ID_W-1:0] m0_rid, m1_rid;
  logic [63:0]     m0_rdata, m1_rdata;
  logic [1:0]      m0_rresp, m1_rresp;
  logic            s_arvalid, s_arready;
  logic [ID_W:0]   s_arid;
  logic [31:0]     s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize;
  logic            s_rvalid, s_rready, s_rlast;
  logic [ID_W:0]   s_rid;
  logic [63:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic            err_unexp_r;

  swerv_axi_rd_arb #(.ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_l(rst_l),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err_unexp_r(err_unexp_r)
  );

  typedef struct packed {
    logic [ID_W:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;
  } ar_t;
  typedef struct packed {
    logic m; logic [ID_W-1:0] rid; logic [63:0] data; logic [1:0] resp; logic last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  act_gnt[$];
  int  total = 0;
  int  bad   = 0;

  // reference model state
  logic m_ptr, m_sv, m_err;
  int   m_cnt[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 1'b0; m_sv = 1'b0; m_err = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    ar_q.delete(); r_q.delete();
  endtask

  task automatic idle_inputs();
    m0_arvalid = 0; m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0;
    m1_arvalid = 0; m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0;
    m0_rready = 1; m1_rready = 1;
    s_arready = 0; s_rvalid = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 0;
  endtask

  // One clock: predict grants/valids at the falling edge, compare, advance model.
  task automatic step();
    logic slot, e0, e1, g0, g1, sel, rr;
    @(negedge clk);
    slot = !m_sv || s_arready;
    e0 = m0_arvalid && (m_cnt[0] < MAX_OUT);
    e1 = m1_arvalid && (m_cnt[1] < MAX_OUT);
    g0 = 1'b0; g1 = 1'b0;
    if (slot) begin
      if (e0 && e1) begin g1 = m_ptr; g0 = !m_ptr; end
      else begin g0 = e0; g1 = e1; end
    end
    sel = s_rid[ID_W];
    chk("m0_arready", m0_arready, g0);
    chk("m1_arready", m1_arready, g1);
    chk("s_arvalid", s_arvalid, m_sv);
    chk("err_unexp_r", err_unexp_r, m_err);
    chk("m0_rvalid", m0_rvalid, s_rvalid && !sel);
    chk("m1_rvalid", m1_rvalid, s_rvalid && sel);
    if (m0_arready) act_gnt.push_back(0);
    if (m1_arready) act_gnt.push_back(1);
    if (g0) begin ar_q.push_back({1'b0, m0_arid, m0_araddr, m0_arlen, m0_arsize}); m_ptr = 1'b1; end
    if (g1) begin ar_q.push_back({1'b1, m1_arid, m1_araddr, m1_arlen, m1_arsize}); m_ptr = 1'b0; end
    m_sv = (g0 || g1) ? 1'b1 : (s_arready ? 1'b0 : m_sv);
    rr = sel ? m1_rready : m0_rready;
    if (s_rvalid && rr) begin
      if (m_cnt[sel] == 0) m_err = 1'b1;
      else if (s_rlast) m_cnt[sel]--;
    end
    if (g0) m_cnt[0]++;
    if (g1) m_cnt[1]++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_r(input logic [ID_W:0] sid, input logic last, input logic [63:0] data);
    s_rvalid = 1'b1; s_rid = sid; s_rlast = last; s_rdata = data; s_rresp = 2'b01;
    r_q.push_back({sid[ID_W], sid[ID_W-1:0], data, 2'b01, last});
  endtask

  // monitor: pops expectations whenever the DUT completes a handshake
  always @(negedge clk) begin
    ar_t ea;
    r_t  er;
    if (rst_l) begin
      if (s_arvalid && s_arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          ea = ar_q.pop_front();
          chk("ar_payload", {s_arid, s_araddr, s_arlen, s_arsize}, ea);
        end
      end
      if (m0_rvalid && m0_rready) begin
        if (r_q.size() == 0) chk("r0_unexpected", 1, 0);
        else begin
          er = r_q.pop_front();
          chk("r0_beat", {1'b0, m0_rid, m0_rdata, m0_rresp, m0_rlast}, er);
        end
      end
      if (m1_rvalid && m1_rready) begin
        if (r_q.size() == 0) chk("r1_unexpected", 1, 0);
        else begin
          er = r_q.pop_front();
          chk("r1_beat", {1'b1, m1_rid, m1_rdata, m1_rresp, m1_rlast}, er);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int exp_a[4];
    idle_inputs();
    model_reset();
    m0_arvalid = 1; m1_arvalid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_err", err_unexp_r, 0);
    chk("rst_payload", {s_arid, s_araddr, s_arlen, s_arsize}, 0);
    m0_arvalid = 0; m1_arvalid = 0;
    rst_l = 1; s_arready = 1;
    step();

    // alternating grants with both masters always requesting
    act_gnt.delete();
    m0_arvalid = 1; m1_arvalid = 1;
    for (int i = 0; i < 4; i++) begin
      m0_arid = 4'(i); m0_araddr = 32'h1000 + 32'(i * 16); m0_arlen = 8'd1; m0_arsize = 3'd3;
      m1_arid = 4'(9 - i); m1_araddr = 32'h2000 + 32'(i * 16); m1_arlen = 8'd1; m1_arsize = 3'd3;
      step();
    end
    m0_arvalid = 0; m1_arvalid = 0;
    step();
    exp_a = '{0, 1, 0, 1};
    chk("alt_gnt_count", act_gnt.size(), 4);
    for (int i = 0; i < 4 && i < act_gnt.size(); i++) chk("alt_gnt_order", act_gnt[i], exp_a[i]);

    // interleaved R bursts, counters drop on rlast only
    send_r(5'h13, 0, 64'hA1); #1 chk("ilv_m1_rid", m1_rid, 4'h3); step();
    send_r(5'h02, 0, 64'hB1); #1 chk("ilv_m0_rid", m0_rid, 4'h2); step();
    send_r(5'h13, 1, 64'hA2); step();
    send_r(5'h02, 1, 64'hB2); step();
    send_r(5'h11, 1, 64'hC1); step();
    send_r(5'h01, 1, 64'hC2); step();
    s_rvalid = 0; s_rlast = 0;
    step();

    // MAX_OUT stall for m0, m1 still served, release after one rlast
    m0_arvalid = 1;
    for (int i = 0; i < 4; i++) begin
      m0_arid = 4'(i + 4); m0_araddr = 32'h3000 + 32'(i * 64); m0_arlen = 8'd0;
      step();
    end
    act_gnt.delete();
    m1_arvalid = 1; m1_arid = 4'h7; m1_araddr = 32'h4000; m1_arlen = 8'd0;
    step();
    m1_araddr = 32'h4040;
    step();
    m1_arvalid = 0;
    step();
    send_r(5'h04, 1, 64'hD0); step();
    s_rvalid = 0; s_rlast = 0;
    m0_araddr = 32'h3400;
    step();
    m0_arvalid = 0;
    exp_a = '{1, 1, 0, 0};
    chk("stall_gnt_count", act_gnt.size(), 3);
    for (int i = 0; i < 3 && i < act_gnt.size(); i++) chk("stall_gnt_order", act_gnt[i], exp_a[i]);
    for (int i = 0; i < 4; i++) begin send_r(5'h05, 1, 64'(i)); step(); end
    for (int i = 0; i < 2; i++) begin send_r(5'h17, 1, 64'(i + 16)); step(); end
    s_rvalid = 0; s_rlast = 0;
    step();

    // downstream backpressure holds the payload
    act_gnt.delete();
    s_arready = 0;
    m0_arvalid = 1; m0_arid = 4'h5; m0_araddr = 32'hCAFE_0000; m0_arlen = 8'd2; m0_arsize = 3'd2;
    step();
    m0_arid = 4'h6; m0_araddr = 32'hCAFE_0040;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_addr", s_araddr, 32'hCAFE_0000);
      chk("bp_hold_id", s_arid, 5'h05);
    end
    chk("bp_gnt_count", act_gnt.size(), 1);
    s_arready = 1;
    step();
    chk("bp_next_valid", s_arvalid, 1);
    chk("bp_next_addr", s_araddr, 32'hCAFE_0040);
    m0_arvalid = 0;
    step();
    for (int i = 0; i < 2; i++) begin send_r(5'h05, 1, 64'hE0 + 64'(i)); step(); end
    s_rvalid = 0; s_rlast = 0;
    step();

    // beat for idle m1 sets the sticky error
    send_r(5'h17, 1, 64'hBAD); step();
    s_rvalid = 0; s_rlast = 0;
    step();
    chk("err_set", err_unexp_r, 1);
    repeat (3) step();
    chk("err_sticky", err_unexp_r, 1);

    // async reset mid-burst
    s_arready = 0;
    m1_arvalid = 1; m1_arid = 4'h2; m1_araddr = 32'h5000; m1_arlen = 8'd3;
    step();
    m1_arvalid = 0;
    send_r(5'h12, 0, 64'hF0); step();
    m0_arvalid = 1; m1_arvalid = 1;
    s_rvalid = 1; s_rid = 5'h12; s_rlast = 0;
    #2 rst_l = 0;
    #1;
    chk("arst_s_arvalid", s_arvalid, 0);
    chk("arst_m0_arready", m0_arready, 0);
    chk("arst_m1_arready", m1_arready, 0);
    chk("arst_m0_rvalid", m0_rvalid, 0);
    chk("arst_m1_rvalid", m1_rvalid, 0);
    chk("arst_s_rready", s_rready, 0);
    chk("arst_err", err_unexp_r, 0);
    chk("arst_payload", s_araddr, 0);
    model_reset();
    s_rvalid = 0;
    @(posedge clk);
    #1;
    rst_l = 1; s_arready = 1;
    act_gnt.delete();
    step();
    chk("post_rst_gnt_count", act_gnt.size(), 1);
    if (act_gnt.size() > 0) chk("post_rst_first_gnt", act_gnt[0], 0);
    m0_arvalid = 0; m1_arvalid = 0;
    step();
    step();

    chk("ar_queue_empty", ar_q.size(), 0);
    chk("r_queue_empty", r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swerv_axi_rd_arb.md
SWERV_AXI_RD_ARB -- requirements
Module: swerv_axi_rd_arb

Interface
REQ-001 The block SHALL have parameter ID_W, default 4, giving the per-master AXI ID width.
REQ-002 The block SHALL have parameter MAX_OUT, default 4, giving the maximum outstanding read bursts per master (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single core clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst_l, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports m0_arvalid / m1_arvalid, input, 1 bit each: master read-address valid.
REQ-006 The block SHALL have ports m0_arready / m1_arready, output, 1 bit each: master read-address accept.
REQ-007 The block SHALL have ports m0_/m1_ arid, araddr, arlen, arsize, input, widths ID_W/32/8/3: master read-address payload.
REQ-008 The block SHALL have ports m0_/m1_ rvalid, rid, rdata, rresp, rlast, output, widths 1/ID_W/64/2/1: read data returned to each master.
REQ-009 The block SHALL have ports m0_rready / m1_rready, input, 1 bit each: master read-data accept.
REQ-010 The block SHALL have ports s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, output, widths 1/ID_W+1/32/8/3: shared downstream read-address port.
REQ-011 The block SHALL have port s_arready, input, 1 bit: downstream read-address accept.
REQ-012 The block SHALL have ports s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, input, widths 1/ID_W+1/64/2/1: downstream read data.
REQ-013 The block SHALL have port s_rready, output, 1 bit: downstream read-data accept.
REQ-014 The block SHALL have port err_unexp_r, output, 1 bit: sticky flag for an unexpected R beat.

Function
REQ-015 The block SHALL treat a master as eligible when mX_arvalid=1 and its outstanding count < MAX_OUT.
REQ-016 The block SHALL accept an AR only when the output slot is free, i.e. s_arvalid=0 or s_arready=1 in the same cycle.
REQ-017 The block SHALL grant round-robin: with both masters eligible, the master indicated by the priority pointer wins; with one eligible, that master wins.
REQ-018 The block SHALL move the pointer to the non-granted master after each grant and leave it unchanged when nothing is granted.
REQ-019 The block SHALL assert mX_arready combinationally only for the granted master, in the grant cycle.
REQ-020 The block SHALL register the granted AR: an accept in cycle N gives s_arvalid=1 in cycle N+1, with s_arid={grant index, mX_arid}.
REQ-021 The block SHALL hold the s_ar* payload stable while s_arvalid=1 and s_arready=0.
REQ-022 The block SHALL keep per-master outstanding counters: +1 on AR accept, -1 on an R handshake with rlast=1 routed to that master; both in one cycle leaves the count unchanged.
REQ-023 The block SHALL route R combinationally by s_rid[ID_W]: mX_rvalid=s_rvalid for the selected master, s_rready=selected mX_rready, mX_rid=s_rid[ID_W-1:0], and pass data/resp/last through.
REQ-024 The block SHALL, on an R handshake to a master whose count is 0, set err_unexp_r, leave the counter at 0 and still route the beat.
REQ-025 The block SHALL drive the unselected master's rvalid to 0.
REQ-026 The block SHALL keep the R path independent of AR: multi-beat bursts of both masters may interleave per beat, as signalled by s_rid.

Reset
REQ-027 The block SHALL, while rst_l=0, drive s_arvalid=0, mX_arready=0, err_unexp_r=0, counters=0 and pointer=m0, and SHALL clear the payload registers to 0.
REQ-028 The block SHALL treat a reset mid-burst as discarding all outstanding state; no transaction recovery is required.

Structure
REQ-029 Package swerv_arb_pkg SHALL hold the ID width constant, a packed ar_payload_t struct (id, addr, len, size) and the grant-index typedef.
REQ-030 The round-robin arbiter SHALL be a separate sub-module, swerv_arb_rr2 (2 requests, pointer state, 1-hot grant).

Verification
REQ-031 Both masters assert arvalid every cycle with s_arready=1 -> grants alternate m0,m1,m0,m1; s_arid MSB toggles 0,1,0,1.
REQ-032 m0 issues 4 ARs with no R returned, MAX_OUT=4 -> 5th m0 AR stalls (m0_arready=0) while m1 is still granted; one m0 rlast beat -> m0 is granted next free cycle.
REQ-033 s_arready=0 for 3 cycles with s_arvalid=1 -> s_ar* stable, no mX_arready; on release s_arready=1 -> the next AR follows 1 cycle later.
REQ-034 Interleaved R beats s_rid=5'h13 then 5'h02, arlen=1 -> m1 receives rid=3, m0 receives rid=2, counters decrement only on rlast.
REQ-035 R beat with s_rid MSB=1 while m1 count=0 -> err_unexp_r=1 and it stays 1 until rst_l=0.
REQ-036 rst_l low during an outstanding burst -> all outputs 0 asynchronously, counters 0, and the first post-reset grant goes to m0.
